// File: rtl/rwt_tag_extract.sv
// rwt_tag_extract: removes in-band escape sequences from an AXI-Stream and
// turns each escaped control word into a tag attached to the next data beat.
// The output is a single register stage, so latency is one cycle and a new
// beat can be accepted on every cycle.
module rwt_tag_extract #(
   parameter int DWIDTH = 64,
   parameter int TWIDTH = 7
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              use_tags,
   input  logic [DWIDTH-1:0] tag_escape,
   input  logic [DWIDTH-1:0] s_axi_tdata,
   input  logic              s_axi_tvalid,
   output logic              s_axi_tready,
   input  logic              s_axi_tlast,
   output logic [DWIDTH-1:0] m_axi_tdata,
   output logic              m_axi_tvalid,
   input  logic              m_axi_tready,
   output logic              m_axi_tlast,
   output logic              m_axi_tag_valid,
   output logic [TWIDTH-1:0] m_axi_tag_type,
   output logic              tag_err
);

   // DATA: plain words; ESC: previous word was the escape; PEND: a tag waits
   // for the next data beat.
   typedef enum logic [1:0] {
      ST_DATA = 2'd0,
      ST_ESC  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              pend_q, pend_d;
   logic [TWIDTH-1:0] pend_type_q, pend_type_d;
   logic [DWIDTH-1:0] tdata_q, tdata_d;
   logic              tvalid_q, tvalid_d;
   logic              tlast_q, tlast_d;
   logic              tagv_q, tagv_d;
   logic [TWIDTH-1:0] tagt_q, tagt_d;
   logic              err_q, err_d;

   logic              accept;
   logic              is_esc;

   // The output register can take a new beat when it is empty or being drained.
   // Held low during reset so nothing is accepted before the block is ready.
   assign s_axi_tready = aresetn && (!tvalid_q || m_axi_tready);
   assign accept       = s_axi_tvalid && s_axi_tready;
   assign is_esc       = (s_axi_tdata == tag_escape);

   assign m_axi_tdata     = tdata_q;
   assign m_axi_tvalid    = tvalid_q;
   assign m_axi_tlast     = tlast_q;
   assign m_axi_tag_valid = tagv_q;
   assign m_axi_tag_type  = tagt_q;
   assign tag_err         = err_q;

   // Next-state, pending-tag and output-register logic for one accepted word.
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      pend_type_d = pend_type_q;
      tdata_d     = tdata_q;
      tvalid_d    = tvalid_q;
      tlast_d     = tlast_q;
      tagv_d      = tagv_q;
      tagt_d      = tagt_q;
      err_d       = 1'b0;

      // A completed handshake empties the register unless refilled below.
      if (tvalid_q && m_axi_tready) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
         tagv_d   = 1'b0;
         tagt_d   = {TWIDTH{1'b0}};
      end else begin
         tvalid_d = tvalid_q;
      end

      if (!use_tags) begin
         // Transparent mode: no decoding, FSM parked in DATA.
         state_d     = ST_DATA;
         pend_d      = 1'b0;
         pend_type_d = {TWIDTH{1'b0}};
         if (accept) begin
            tvalid_d = 1'b1;
            tdata_d  = s_axi_tdata;
            tlast_d  = s_axi_tlast;
            tagv_d   = 1'b0;
            tagt_d   = {TWIDTH{1'b0}};
         end else begin
            tdata_d = tdata_q;
         end
      end else if (accept) begin
         case (state_q)
            ST_DATA, ST_PEND: begin
               if (is_esc && s_axi_tlast) begin
                  // Escape cannot be completed inside this packet.
                  err_d       = 1'b1;
                  pend_d      = 1'b0;
                  pend_type_d = {TWIDTH{1'b0}};
                  state_d     = ST_DATA;
               end else if (is_esc) begin
                  state_d = ST_ESC;
               end else begin
                  tvalid_d    = 1'b1;
                  tdata_d     = s_axi_tdata;
                  tlast_d     = s_axi_tlast;
                  tagv_d      = pend_q;
                  tagt_d      = pend_q ? pend_type_q : {TWIDTH{1'b0}};
                  pend_d      = 1'b0;
                  pend_type_d = {TWIDTH{1'b0}};
                  state_d     = ST_DATA;
               end
            end
            ST_ESC: begin
               if (is_esc) begin
                  // Doubled escape is a literal escape-valued data word.
                  tvalid_d    = 1'b1;
                  tdata_d     = s_axi_tdata;
                  tlast_d     = s_axi_tlast;
                  tagv_d      = pend_q;
                  tagt_d      = pend_q ? pend_type_q : {TWIDTH{1'b0}};
                  pend_d      = 1'b0;
                  pend_type_d = {TWIDTH{1'b0}};
                  state_d     = ST_DATA;
               end else if (s_axi_tlast) begin
                  // Control word ending a packet has nothing to tag.
                  err_d       = 1'b1;
                  pend_d      = 1'b0;
                  pend_type_d = {TWIDTH{1'b0}};
                  state_d     = ST_DATA;
               end else begin
                  // Overwriting an unused tag is flagged but the new one wins.
                  err_d       = pend_q;
                  pend_d      = 1'b1;
                  pend_type_d = s_axi_tdata[TWIDTH-1:0];
                  state_d     = ST_PEND;
               end
            end
            default: begin
               pend_d      = 1'b0;
               pend_type_d = {TWIDTH{1'b0}};
               state_d     = ST_DATA;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_q     <= ST_DATA;
         pend_q      <= 1'b0;
         pend_type_q <= {TWIDTH{1'b0}};
         tdata_q     <= {DWIDTH{1'b0}};
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
         tagv_q      <= 1'b0;
         tagt_q      <= {TWIDTH{1'b0}};
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         pend_type_q <= pend_type_d;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         tlast_q     <= tlast_d;
         tagv_q      <= tagv_d;
         tagt_q      <= tagt_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_rwt_tag_extract.sv
// Directed bench for rwt_tag_extract: expected beats go into a scoreboard
// queue as stimulus is written and are compared as the DUT emits them.
module tb_rwt_tag_extract;

   localparam logic [63:0] ESC = 64'hAAAA_AAAA_AAAA_AAAA;

   typedef struct packed {
      logic [63:0] d;
      logic        l;
      logic        tv;
      logic [6:0]  tt;
   } beat_t;

   logic        clk = 1'b0;
   logic        aresetn;
   logic        use_tags;
   logic [63:0] tag_escape;
   logic [63:0] s_axi_tdata;
   logic        s_axi_tvalid;
   logic        s_axi_tready;
   logic        s_axi_tlast;
   logic [63:0] m_axi_tdata;
   logic        m_axi_tvalid;
   logic        m_axi_tready;
   logic        m_axi_tlast;
   logic        m_axi_tag_valid;
   logic [6:0]  m_axi_tag_type;
   logic        tag_err;

   int    errors  = 0;
   int    checks  = 0;
   int    err_cnt = 0;
   int    exp_err = 0;
   int    bp_mode = 0;  // 0: always ready, 1: random, 2: always stalled
   beat_t sb[$];

   rwt_tag_extract #(.DWIDTH(64), .TWIDTH(7)) dut (
      .clk(clk), .aresetn(aresetn), .use_tags(use_tags), .tag_escape(tag_escape),
      .s_axi_tdata(s_axi_tdata), .s_axi_tvalid(s_axi_tvalid), .s_axi_tready(s_axi_tready),
      .s_axi_tlast(s_axi_tlast), .m_axi_tdata(m_axi_tdata), .m_axi_tvalid(m_axi_tvalid),
      .m_axi_tready(m_axi_tready), .m_axi_tlast(m_axi_tlast), .m_axi_tag_valid(m_axi_tag_valid),
      .m_axi_tag_type(m_axi_tag_type), .tag_err(tag_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [63:0] d, input logic l, input logic tv, input logic [6:0] tt);
      beat_t b;
      b.d = d; b.l = l; b.tv = tv; b.tt = tt;
      sb.push_back(b);
   endtask

   // Drive one word and hold it until the DUT accepts it; returns on a negedge.
   task automatic send(input logic [63:0] w, input logic l);
      logic acc;
      acc = 1'b0;
      s_axi_tdata  = w;
      s_axi_tlast  = l;
      s_axi_tvalid = 1'b1;
      for (int i = 0; i < 1000 && !acc; i++) begin
         #1;
         acc = s_axi_tready;
         @(posedge clk);
         @(negedge clk);
      end
      if (!acc) chk("send_timeout", {79'd0, s_axi_tready}, 80'd1);
      s_axi_tvalid = 1'b0;
      s_axi_tlast  = 1'b0;
   endtask

   // Wait for the scoreboard to empty, then check the tag_err pulse count.
   task automatic drain(input string tag);
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         #3;
         if (i >= 2 && sb.size() == 0) break;
      end
      chk({tag, "_drain"}, 80'(sb.size()), 80'd0);
      chk({tag, "_tag_err"}, 80'(err_cnt), 80'(exp_err));
      @(negedge clk);
   endtask

   // Output-side ready generator.
   initial begin
      m_axi_tready = 1'b1;
      forever begin
         @(negedge clk);
         if (bp_mode == 1)      m_axi_tready = 1'($urandom_range(0, 1));
         else if (bp_mode == 2) m_axi_tready = 1'b0;
         else                   m_axi_tready = 1'b1;
      end
   end

   // Monitor: pops the scoreboard on each output handshake, counts tag_err
   // cycles and checks that a stalled beat does not change.
   initial begin
      beat_t cur;
      beat_t held_b;
      logic  held;
      held = 1'b0;
      held_b = '0;
      forever begin
         @(negedge clk);
         #2;
         cur = {m_axi_tdata, m_axi_tlast, m_axi_tag_valid, m_axi_tag_type};
         if (aresetn === 1'b1 && m_axi_tvalid === 1'b1 && m_axi_tready === 1'b1) begin
            if (sb.size() == 0) chk("spurious_beat", {79'd0, m_axi_tvalid}, 80'd0);
            else chk("beat", {7'd0, cur}, {7'd0, sb.pop_front()});
         end
         if (tag_err === 1'b1) err_cnt++;
         if (m_axi_tvalid === 1'b1 && m_axi_tready === 1'b0) begin
            if (held) chk("stall_stable", {7'd0, cur}, {7'd0, held_b});
            held_b = cur;
            held   = 1'b1;
         end else begin
            held = 1'b0;
         end
      end
   end

   initial begin
      logic [63:0] w;
      logic        l;
      aresetn      = 1'b0;
      use_tags     = 1'b1;
      tag_escape   = ESC;
      s_axi_tdata  = 64'd0;
      s_axi_tvalid = 1'b0;
      s_axi_tlast  = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      #1;
      chk("rst_tvalid", {79'd0, m_axi_tvalid}, 80'd0);
      chk("rst_tlast", {79'd0, m_axi_tlast}, 80'd0);
      chk("rst_tagv", {79'd0, m_axi_tag_valid}, 80'd0);
      chk("rst_tagt", {73'd0, m_axi_tag_type}, 80'd0);
      chk("rst_err", {79'd0, tag_err}, 80'd0);
      chk("rst_tdata", {16'd0, m_axi_tdata}, 80'd0);
      chk("rst_sready", {79'd0, s_axi_tready}, 80'd0);
      @(negedge clk);
      aresetn = 1'b1;
      #1;
      chk("rel_sready", {79'd0, s_axi_tready}, 80'd1);
      @(negedge clk);

      // Plain data.
      push(64'h1, 1'b0, 1'b0, 7'd0); send(64'h1, 1'b0);
      push(64'h2, 1'b1, 1'b0, 7'd0); send(64'h2, 1'b1);
      drain("plain");

      // Control word tags the next data beat only.
      send(ESC, 1'b0); send(64'h05, 1'b0);
      push(64'h10, 1'b0, 1'b1, 7'd5); send(64'h10, 1'b0);
      push(64'h11, 1'b1, 1'b0, 7'd0); send(64'h11, 1'b1);
      drain("tag");

      // Doubled escape is a literal.
      send(ESC, 1'b0);
      push(ESC, 1'b0, 1'b0, 7'd0); send(ESC, 1'b0);
      push(64'h7, 1'b1, 1'b0, 7'd0); send(64'h7, 1'b1);
      drain("literal");

      // Second control word while pending: error, new type wins.
      send(ESC, 1'b0); send(64'h03, 1'b0); send(ESC, 1'b0); send(64'h09, 1'b0);
      exp_err++;
      push(64'h20, 1'b1, 1'b1, 7'd9); send(64'h20, 1'b1);
      drain("overwrite");

      // Escape with tlast is dropped; next packet decodes normally.
      push(64'h1, 1'b0, 1'b0, 7'd0); send(64'h1, 1'b0);
      send(ESC, 1'b1);
      exp_err++;
      send(ESC, 1'b0); send(64'h02, 1'b0);
      push(64'h33, 1'b1, 1'b1, 7'd2); send(64'h33, 1'b1);
      drain("esc_last");

      // Control word with tlast is dropped and leaves nothing pending.
      send(ESC, 1'b0); send(64'h04, 1'b1);
      exp_err++;
      push(64'h44, 1'b1, 1'b0, 7'd0); send(64'h44, 1'b1);
      drain("ctl_last");

      // Tag on a tlast beat does not leak into the next packet.
      send(ESC, 1'b0); send(64'h06, 1'b0);
      push(64'h55, 1'b1, 1'b1, 7'd6); send(64'h55, 1'b1);
      push(64'h56, 1'b1, 1'b0, 7'd0); send(64'h56, 1'b1);
      drain("boundary");

      // Escape while pending keeps the tag for a following literal.
      send(ESC, 1'b0); send(64'h08, 1'b0); send(ESC, 1'b0);
      push(ESC, 1'b0, 1'b1, 7'd8); send(ESC, 1'b0);
      push(64'h57, 1'b1, 1'b0, 7'd0); send(64'h57, 1'b1);
      drain("pend_esc");

      // Transparent mode under random backpressure, escapes included.
      use_tags = 1'b0;
      bp_mode  = 1;
      for (int i = 0; i < 40; i++) begin
         w = {$urandom, $urandom};
         if (i == 5 || i == 6 || i == 7) w = ESC;
         l = (i % 8 == 7);
         push(w, l, 1'b0, 7'd0);
         send(w, l);
      end
      bp_mode = 0;
      drain("passthru");

      // Reset mid-packet with a tag pending and a beat stalled at the output.
      use_tags = 1'b1;
      bp_mode  = 2;
      @(negedge clk);
      send(ESC, 1'b0); send(64'h03, 1'b0); send(64'h01, 1'b0);
      aresetn = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_tvalid", {79'd0, m_axi_tvalid}, 80'd0);
      chk("mid_rst_sready", {79'd0, s_axi_tready}, 80'd0);
      chk("mid_rst_tagv", {79'd0, m_axi_tag_valid}, 80'd0);
      chk("mid_rst_tdata", {16'd0, m_axi_tdata}, 80'd0);
      bp_mode = 0;
      @(negedge clk);
      @(negedge clk);
      aresetn = 1'b1;
      #1;
      chk("mid_rel_sready", {79'd0, s_axi_tready}, 80'd1);
      @(negedge clk);
      push(64'h05, 1'b0, 1'b0, 7'd0); send(64'h05, 1'b0);
      push(64'h06, 1'b1, 1'b0, 7'd0); send(64'h06, 1'b1);
      drain("after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/rwt_tag_extract.md
RWT_TAG_EXTRACT -- requirements
Module: rwt_tag_extract

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, meaning the data width of the input and output streams.
REQ-002 SHALL have parameter TWIDTH, default 7, meaning the tag-type width, taken from control-word bits [TWIDTH-1:0].
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 aresetn  in  1  reset, synchronous, active-low.
REQ-005 use_tags  in  1  1 = decode escapes; 0 = transparent pass-through.
REQ-006 tag_escape  in  DWIDTH  escape word value; quasi-static.
REQ-007 s_axi_tdata / s_axi_tvalid / s_axi_tready / s_axi_tlast  in/in/out/in  DWIDTH/1/1/1  escaped input stream.
REQ-008 m_axi_tdata / m_axi_tvalid / m_axi_tready / m_axi_tlast  out/out/in/out  DWIDTH/1/1/1  decoded data stream.
REQ-009 m_axi_tag_valid  out  1  the current output beat carries a tag.
REQ-010 m_axi_tag_type  out  TWIDTH  tag type for that beat; 0 when m_axi_tag_valid=0.
REQ-011 tag_err  out  1  one-cycle pulse on a protocol violation.

Function
REQ-012 SHALL accept an input beat only when s_axi_tvalid and s_axi_tready are both high.
REQ-013 s_axi_tready SHALL be !m_axi_tvalid || m_axi_tready (single output register, full throughput).
REQ-014 Output data SHALL appear on m_axi_* one cycle after the accepting input beat; latency is 1.
REQ-015 Output beat fields SHALL hold stable while m_axi_tvalid=1 and m_axi_tready=0.
REQ-016 m_axi_tvalid SHALL deassert after a handshake with no new output beat in the same cycle.
REQ-017 The FSM SHALL have three states: DATA, ESC, and PEND.
REQ-018 DATA state:
- word != tag_escape -> emit data beat; if a pending tag exists, attach it and clear it.
- word == tag_escape -> go to ESC; no output.
REQ-019 ESC state, next word == tag_escape -> emit one literal tag_escape data beat (with pending tag if any); return to DATA.
REQ-020 ESC state, next word != tag_escape -> control word:
- latch type = word[TWIDTH-1:0]; set pending.
- go to PEND; no output.
REQ-021 PEND state SHALL behave as DATA and return to DATA when the tagged beat is emitted; an escape in PEND SHALL move to ESC with pending kept.
REQ-022 A control word arriving while a tag is already pending SHALL:
- overwrite the pending type;
- pulse tag_err for one cycle.
REQ-023 An escape word with s_axi_tlast=1 SHALL:
- be discarded;
- pulse tag_err;
- clear any pending tag;
- return the FSM to DATA.
REQ-024 A control word with tlast=1 SHALL be discarded and pulse tag_err, with pending cleared and return to DATA.
REQ-025 tlast on a data or literal beat SHALL pass to m_axi_tlast.
REQ-026 A pending tag SHALL NOT cross a packet boundary: it is cleared after any tlast beat.
REQ-027 With use_tags=0:
- every input word SHALL pass unchanged, latency 1;
- m_axi_tag_valid=0;
- the FSM SHALL be held in DATA;
- tag_err=0.
REQ-028 use_tags changes SHALL take effect only between packets; mid-packet changes are undefined.

Reset
REQ-029 While aresetn=0, on each clock edge:
- m_axi_tvalid=0, m_axi_tlast=0, m_axi_tag_valid=0, m_axi_tag_type=0, tag_err=0, m_axi_tdata=0;
- FSM=DATA; pending cleared.
REQ-030 s_axi_tready SHALL be 0 during reset.
REQ-031 Reset mid-packet SHALL discard all partial state with no spurious output after release.
REQ-032 Output SHALL be ready to accept data on the first cycle after release.

Verification
REQ-033 Escape=AAAA_AAAA_AAAA_AAAA; input 0x1, 0x2 (tlast), m_axi_tready=1 -> outputs 0x1, 0x2 (tlast), no tags, one cycle latency each.
REQ-034 Input ESC, 0x05, 0x10, 0x11 (tlast) -> output 0x10 with tag_valid=1 and tag_type=5, then 0x11 (tlast) with tag_valid=0.
REQ-035 Input ESC, ESC, 0x7 (tlast) -> output AAAA_AAAA_AAAA_AAAA, then 0x7; no tags; tag_err=0.
REQ-036 Input ESC, 0x03, ESC, 0x09, 0x20 -> one tag_err pulse; 0x20 tagged with type 9.
REQ-037 Input 0x1, ESC (tlast) -> output 0x1 only; tag_err pulses; the next packet decodes normally.
REQ-038 Random m_axi_tready backpressure with use_tags=0 -> output stream is bit-exact to the input and stable while stalled; assert aresetn=0 mid-packet -> m_axi_tvalid=0 on the next edge.
